led_pattern_engine: RTL and testbench

Parametrised multi-channel LED driver. It is the successor to the single free-running-counter blinky on the TinyFPGA A1 board. Each channel independently runs one of four modes: OFF, steady PWM dim (ON), BLINK or BREATHE, with per-channel brightness level. It sits between the internal oscillator clock domain and the board's LED pins, and is configured by a simple one-cycle write strobe from a host or a top-level pattern sequencer.

---
 rtl/led_pattern_engine.sv | 124 ++++++++++++
 tb/tb_led_pattern_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// Multi-channel LED pattern engine: per-channel OFF / ON / BLINK / BREATHE modes
// driven by a shared tick prescaler and a shared PWM counter.
module led_pattern_engine #(
  parameter int NUM_CH      = 3,
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 8192,
  parameter int BLINK_TICKS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_level,
  output logic                tick,
  output logic [NUM_CH-1:0]   led_out
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam int PS_W = $clog2(PRESCALE);
  localparam int BC_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PS_W-1:0]     r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  mode_e               r_mode        [NUM_CH];
  logic [PWM_BITS-1:0] r_level       [NUM_CH];
  logic [PWM_BITS-1:0] r_ramp        [NUM_CH];
  logic                r_dir_down    [NUM_CH];
  logic [BC_W-1:0]     r_blink_cnt   [NUM_CH];
  logic                r_blink_phase [NUM_CH];
  logic [PWM_BITS-1:0] w_duty        [NUM_CH];
  logic                w_cfg_ok;

  assign tick     = (r_presc == PS_W'(PRESCALE - 1));
  assign w_cfg_ok = cfg_we && ({1'b0, cfg_ch} < 5'(NUM_CH));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_presc   <= tick ? '0 : r_presc + PS_W'(1);
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  // NOTE: per-channel arrays are a handful of flops, not a RAM, so they are
  // reset explicitly; a true memory would be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_mode[i]        <= MODE_OFF;
        r_level[i]       <= '0;
        r_ramp[i]        <= '0;
        r_dir_down[i]    <= 1'b0;
        r_blink_cnt[i]   <= '0;
        r_blink_phase[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cfg_ok && (cfg_ch == 4'(i))) begin
          // A write restarts the pattern and takes priority over a same-cycle tick.
          r_mode[i]        <= mode_e'(cfg_mode);
          r_level[i]       <= cfg_level;
          r_ramp[i]        <= '0;
          r_dir_down[i]    <= 1'b0;
          r_blink_cnt[i]   <= '0;
          r_blink_phase[i] <= 1'b1;
        end else if (tick) begin
          if (r_mode[i] == MODE_BLINK) begin
            if (r_blink_cnt[i] == BC_W'(BLINK_TICKS - 1)) begin
              r_blink_cnt[i]   <= '0;
              r_blink_phase[i] <= ~r_blink_phase[i];
            end else begin
              r_blink_cnt[i] <= r_blink_cnt[i] + BC_W'(1);
            end
          end else if (r_mode[i] == MODE_BREATHE && r_level[i] != '0) begin
            if (!r_dir_down[i]) begin
              r_ramp[i] <= r_ramp[i] + PWM_BITS'(1);
              if (r_ramp[i] + PWM_BITS'(1) == r_level[i]) r_dir_down[i] <= 1'b1;
            end else begin
              r_ramp[i] <= r_ramp[i] - PWM_BITS'(1);
              if (r_ramp[i] == PWM_BITS'(1)) r_dir_down[i] <= 1'b0;
            end
          end
        end
      end
    end
  end

  // NOTE: default assigned first so no path leaves w_duty unassigned (no latch).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_duty[i] = '0;
      unique case (r_mode[i])
        MODE_OFF:     w_duty[i] = '0;
        MODE_ON:      w_duty[i] = r_level[i];
        MODE_BLINK:   w_duty[i] = r_blink_phase[i] ? r_level[i] : '0;
        MODE_BREATHE: w_duty[i] = r_ramp[i];
      endcase
    end
  end

  // All-ones duty is forced high so full brightness has no dark cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        led_out[i] <= (w_duty[i] == '1) || (r_pwm_cnt < w_duty[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed scenarios plus random
// config writes, compared each cycle against a ticks-since-write reference model.
module tb_led_pattern_engine;

  localparam int NUM_CH      = 3;
  localparam int PWM_BITS    = 4;
  localparam int PRESCALE    = 4;
  localparam int BLINK_TICKS = 2;
  localparam int PWM_PERIOD  = 1 << PWM_BITS;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_we;
  logic [3:0]          cfg_ch;
  logic [1:0]          cfg_mode;
  logic [PWM_BITS-1:0] cfg_level;
  logic                tick;
  logic [NUM_CH-1:0]   led_out;

  int total = 0;
  int bad   = 0;

  // Reference model: cycle count since reset release, plus per-channel
  // mode, level and number of pattern ticks seen since the last write.
  int              c;
  int              m_mode  [NUM_CH];
  int              m_level [NUM_CH];
  int              m_k     [NUM_CH];
  logic [NUM_CH-1:0] exp_led;
  logic            exp_tick;

  led_pattern_engine #(
    .NUM_CH     (NUM_CH),
    .PWM_BITS   (PWM_BITS),
    .PRESCALE   (PRESCALE),
    .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_level(cfg_level),
    .tick     (tick),
    .led_out  (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int duty_of(input int ch);
    int l;
    int k;
    int r;
    l = m_level[ch];
    k = m_k[ch];
    case (m_mode[ch])
      1: return l;
      2: return (((k / BLINK_TICKS) % 2) == 0) ? l : 0;
      3: begin
        if (l == 0) return 0;
        r = k % (2 * l);
        return (r <= l) ? r : (2 * l - r);
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    c = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_mode[i]  = 0;
      m_level[i] = 0;
      m_k[i]     = 0;
    end
    exp_led  = '0;
    exp_tick = 1'b0;
  endtask

  // Called at a falling edge: drives inputs, advances the model across the
  // next rising edge, then checks outputs at the following falling edge.
  task automatic step(input bit we, input int ch, input int mode, input int lvl);
    bit tick_pre;
    int d;
    cfg_we    = we;
    cfg_ch    = 4'(ch);
    cfg_mode  = 2'(mode);
    cfg_level = PWM_BITS'(lvl);
    if (!rst) begin
      tick_pre = ((c % PRESCALE) == PRESCALE - 1);
      for (int i = 0; i < NUM_CH; i++) begin
        d = duty_of(i);
        exp_led[i] = (d == PWM_PERIOD - 1) || ((c % PWM_PERIOD) < d);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (we && ch == i) begin
          m_mode[i]  = mode;
          m_level[i] = lvl;
          m_k[i]     = 0;
        end else if (tick_pre && m_mode[i] >= 2) begin
          m_k[i]++;
        end
      end
      c++;
      exp_tick = ((c % PRESCALE) == PRESCALE - 1);
    end
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    check("led_out", 32'(led_out), 32'(exp_led));
    check("tick", 32'(tick), 32'(exp_tick));
  endtask

  task automatic run(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  initial begin
    int ones;
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    cfg_level = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led_out), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    rst = 1'b0;

    // Tick cadence with everything off.
    run(12);

    // Steady PWM: level 5 gives 5 high cycles per 16.
    step(1, 0, 1, 5);
    run(16);
    ones = 0;
    for (int i = 0; i < PWM_PERIOD; i++) begin
      step(0, 0, 0, 0);
      ones += int'(led_out[0]);
    end
    check("pwm5_high_count", 32'(ones), 32'd5);
    step(1, 0, 1, 15);
    run(20);
    step(1, 0, 1, 0);
    run(20);

    // Blink and breathe.
    step(1, 1, 2, 15);
    run(40);
    step(1, 2, 3, 3);
    run(60);
    step(1, 2, 3, 0);
    run(20);

    // Write landing on a tick cycle for ch2 while ch1 blinks.
    step(1, 2, 3, 3);
    run(10);
    for (int b = 0; b < PRESCALE && (c % PRESCALE) != PRESCALE - 1; b++) step(0, 0, 0, 0);
    check("collide_on_tick", 32'(tick), 32'd1);
    step(1, 2, 3, 3);
    run(40);

    // Out-of-range channel writes are ignored.
    step(1, 5, 1, 15);
    step(1, 4, 2, 9);
    step(1, 15, 3, 7);
    run(20);

    // Asynchronous reset in the middle of a lit ON pattern.
    step(1, 0, 1, 8);
    for (int b = 0; b < PWM_PERIOD && exp_led[0] != 1'b1; b++) step(0, 0, 0, 0);
    check("pre_reset_lit", 32'(led_out[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_led", 32'(led_out), 32'd0);
    check("async_reset_tick", 32'(tick), 32'd0);
    model_reset();
    @(negedge clk);
    check("held_reset_led", 32'(led_out), 32'd0);
    rst = 1'b0;
    run(20);

    // Independence: three modes at once for 1000 ticks.
    step(1, 0, 1, 9);
    step(1, 1, 2, 7);
    step(1, 2, 3, 5);
    run(1000 * PRESCALE);

    // Random config traffic, including out-of-range channels.
    repeat (2000) begin
      if ($urandom_range(0, 7) == 0)
        step(1, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      else
        step(0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
